// File: rtl/stream_matrix_writer.sv
// Streams row-major elements into a NUM_ROWS x NUM_COLS matrix write port.
// Tracks us_last against the expected element count and flags mismatches.
module stream_matrix_writer #(
    parameter int  WIDTH          = 32,
    parameter int  NUM_ROWS       = 4,
    parameter int  NUM_COLS       = 5,
    localparam int ROW_ADDR_WIDTH = $clog2(NUM_ROWS),
    localparam int COL_ADDR_WIDTH = $clog2(NUM_COLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          us_data,
    input  logic                      us_valid,
    input  logic                      us_last,
    output logic                      us_next_data,
    output logic [ROW_ADDR_WIDTH-1:0] write_row_addr,
    output logic [COL_ADDR_WIDTH-1:0] write_col_addr,
    output logic [WIDTH-1:0]          write_data,
    output logic                      write_ready,
    output logic                      done,
    output logic                      last_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [ROW_ADDR_WIDTH-1:0] ROW_LAST = ROW_ADDR_WIDTH'(NUM_ROWS - 1);
    localparam logic [COL_ADDR_WIDTH-1:0] COL_LAST = COL_ADDR_WIDTH'(NUM_COLS - 1);

    state_t                    state_q, state_d;
    logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
    logic [COL_ADDR_WIDTH-1:0] col_q, col_d;
    logic [ROW_ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
    logic [COL_ADDR_WIDTH-1:0] wr_col_q, wr_col_d;
    logic [WIDTH-1:0]          wr_data_q, wr_data_d;
    logic                      wr_valid_q, wr_valid_d;
    logic                      err_q, err_d;
    logic                      is_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            err_q      <= err_d;
        end
    end

    assign is_final = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RECEIVE;
                    row_d   = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RECEIVE: begin
                if (us_valid) begin
                    wr_valid_d = 1'b1;
                    wr_row_d   = row_q;
                    wr_col_d   = col_q;
                    wr_data_d  = us_data;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    // Either the count runs out or us_last arrives early;
                    // any disagreement between the two is an error.
                    if (is_final || us_last) begin
                        state_d = DONE;
                        if (is_final != us_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign us_next_data   = (state_q == RECEIVE);
    assign done           = (state_q == DONE);
    assign write_ready    = wr_valid_q;
    assign write_row_addr = wr_row_q;
    assign write_col_addr = wr_col_q;
    assign write_data     = wr_data_q;
    assign last_error     = err_q;

endmodule

// File: tb/tb_stream_matrix_writer.sv
// Scoreboard bench for stream_matrix_writer: drives element streams and
// checks every matrix write, done pulse and last_error outcome.
module tb_stream_matrix_writer;

    localparam int WIDTH = 32;
    localparam int NR    = 4;
    localparam int NC    = 5;
    localparam int N     = NR * NC;

    typedef struct packed {
        logic        done;
        logic [1:0]  row;
        logic [2:0]  col;
        logic [31:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] us_data = '0;
    logic             us_valid = 1'b0;
    logic             us_last = 1'b0;
    logic             us_next_data;
    logic [1:0]       write_row_addr;
    logic [2:0]       write_col_addr;
    logic [WIDTH-1:0] write_data;
    logic             write_ready;
    logic             done;
    logic             last_error;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   wr_cnt = 0;
    exp_t sb[$];
    logic [31:0] mem [NR][NC];

    stream_matrix_writer #(.WIDTH(WIDTH), .NUM_ROWS(NR), .NUM_COLS(NC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .us_data(us_data), .us_valid(us_valid), .us_last(us_last),
        .us_next_data(us_next_data),
        .write_row_addr(write_row_addr), .write_col_addr(write_col_addr),
        .write_data(write_data), .write_ready(write_ready),
        .done(done), .last_error(last_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f32(input int n);
        int e;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    // Write monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (write_ready) begin
            wr_cnt++;
            checks++;
            if (rst || sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got (%0d,%0d)=%h, required no write",
                         write_row_addr, write_col_addr, write_data);
            end else begin
                e = sb.pop_front();
                if ({done, write_row_addr, write_col_addr, write_data} !== e) begin
                    errors++;
                    $display("FAIL write: got done=%b (%0d,%0d)=%h, required done=%b (%0d,%0d)=%h",
                             done, write_row_addr, write_col_addr, write_data,
                             e.done, e.row, e.col, e.data);
                end
                mem[write_row_addr][write_col_addr] = write_data;
            end
        end else if (done) begin
            checks++;
            errors++;
            $display("FAIL done_alone: got done=1 without write, required 0");
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic stream(input int n, input int last_idx, input bit toggle,
                          input int start_at);
        int idx, cyc;
        bit pulsed;
        exp_t e;
        idx = 0; cyc = 0; pulsed = 0;
        while (idx < n && cyc < 200) begin
            us_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            us_data  = f32(idx + 1);
            us_last  = (idx == last_idx);
            start    = (idx == start_at) && !pulsed;
            if (start) pulsed = 1;
            @(negedge clk);
            if (us_valid && us_next_data) begin
                e.done = (idx == N - 1) || (idx == last_idx);
                e.row  = 2'(idx / NC);
                e.col  = 3'(idx % NC);
                e.data = f32(idx + 1);
                sb.push_back(e);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        us_valid = 1'b0; us_last = 1'b0; start = 1'b0;
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL stream_timeout: got %0d accepted, required %0d", idx, n);
        end
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: got %0d pending, required 0", name, sb.size());
        end
    endtask

    task automatic check_end(input string name, input bit err_exp);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt);
        end
        checks++;
        if (last_error !== err_exp) begin
            errors++;
            $display("FAIL %s_last_error: got %b, required %b", name, last_error, err_exp);
        end
        checks++;
        if (us_next_data !== 1'b0) begin
            errors++;
            $display("FAIL %s_next_data_idle: got %b, required 0", name, us_next_data);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({us_next_data, write_ready, write_row_addr, write_col_addr,
             write_data, done, last_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nd=%b wr=%b (%0d,%0d)=%h done=%b err=%b, required all 0",
                     us_next_data, write_ready, write_row_addr, write_col_addr,
                     write_data, done, last_error);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        int bad;
        done_cnt = 0; wr_cnt = 0;
        do_start();
        stream(N, N - 1, 1'b0, -1);
        drain("full");
        check_end("full", 1'b0);
        checks++;
        if (wr_cnt !== N) begin
            errors++;
            $display("FAIL full_write_count: got %0d, required %0d", wr_cnt, N);
        end
        bad = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (mem[r][c] !== f32(r * NC + c + 1)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_readback: got %0d wrong cells, required 0", bad);
        end
    endtask

    task automatic test_stall();
        done_cnt = 0; wr_cnt = 0;
        do_start();
        stream(N, N - 1, 1'b1, -1);
        drain("stall");
        check_end("stall", 1'b0);
        checks++;
        if (wr_cnt !== N) begin
            errors++;
            $display("FAIL stall_write_count: got %0d, required %0d", wr_cnt, N);
        end
    endtask

    task automatic test_early_last();
        done_cnt = 0; wr_cnt = 0;
        do_start();
        stream(7, 6, 1'b0, -1);
        us_valid = 1'b1;
        drain("early");
        us_valid = 1'b0;
        check_end("early", 1'b1);
        checks++;
        if (wr_cnt !== 7) begin
            errors++;
            $display("FAIL early_write_count: got %0d, required 7", wr_cnt);
        end
    endtask

    task automatic test_missing_last();
        done_cnt = 0; wr_cnt = 0;
        do_start();
        stream(N, -1, 1'b0, -1);
        drain("nolast");
        check_end("nolast", 1'b1);
        do_start();
        checks++;
        if (last_error !== 1'b0 || us_next_data !== 1'b1) begin
            errors++;
            $display("FAIL nolast_clear_on_start: got err=%b nd=%b, required err=0 nd=1",
                     last_error, us_next_data);
        end
        done_cnt = 0;
        stream(N, N - 1, 1'b0, -1);
        drain("nolast_rerun");
        check_end("nolast_rerun", 1'b0);
    endtask

    task automatic test_reset_mid();
        stream(0, -1, 1'b0, -1);
        do_start();
        stream(10, -1, 1'b0, -1);
        @(posedge clk); #3;
        rst = 1'b1;
        us_valid = 1'b1;
        #1;
        checks++;
        if ({us_next_data, write_ready, write_row_addr, write_col_addr,
             write_data, done, last_error} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got nd=%b wr=%b (%0d,%0d)=%h done=%b err=%b, required all 0",
                     us_next_data, write_ready, write_row_addr, write_col_addr,
                     write_data, done, last_error);
        end
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        us_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        done_cnt = 0; wr_cnt = 0;
        do_start();
        stream(N, N - 1, 1'b0, -1);
        drain("midreset");
        check_end("midreset", 1'b0);
    endtask

    task automatic test_start_in_receive();
        done_cnt = 0; wr_cnt = 0;
        do_start();
        stream(N, N - 1, 1'b0, 8);
        drain("restart");
        check_end("restart", 1'b0);
        checks++;
        if (wr_cnt !== N) begin
            errors++;
            $display("FAIL restart_write_count: got %0d, required %0d", wr_cnt, N);
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_stall();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        test_start_in_receive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

endmodule
